// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot hold, load-use stall, redirect squash,
// halt/drain/resume, plus saturating stall/flush event counters.
module fetch_ctrl #(
   parameter int BOOT_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_mem_pc_src,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int MAXC = (BOOT_CYCLES > DRAIN_CYCLES) ?
                         BOOT_CYCLES : DRAIN_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] BOOT_INIT  = CW'(BOOT_CYCLES - 1);
   localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic hazard;
   logic stall_ev;
   logic flush_ev;

   assign hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == if_id_rs) ||
                    (if_id_uses_rt && (id_ex_rt == if_id_rt)));

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      halted       = 1'b0;
      stall_ev     = 1'b0;
      flush_ev     = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         S_BOOT: begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            cnt_d        = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_RUN;
         end
         S_RUN: begin
            if (ex_mem_pc_src) begin
               pc_write     = 1'b1;
               if_id_write  = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               flush_ev     = 1'b1;
            end else if (hazard) begin
               id_ex_flush  = 1'b1;
               stall_ev     = 1'b1;
            end else begin
               pc_write     = 1'b1;
               if_id_write  = 1'b1;
            end
            if (halt_req) begin
               state_d = S_DRAIN;
               cnt_d   = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            // A late redirect must still land in PC so resume fetches the target
            if_id_flush = 1'b1;
            if (ex_mem_pc_src) begin
               pc_write     = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               flush_ev     = 1'b1;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_HALTED;
         end
         S_HALTED: begin
            halted      = 1'b1;
            if_id_flush = 1'b1;
            if (resume) state_d = S_RUN;
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_ev && !(&stall_q)) stall_d = stall_q + 1'b1;
      if (flush_ev && !(&flush_q)) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         cnt_q   <= BOOT_INIT;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed literal checks, then random traffic
// compared every cycle against a cycle-count model of the sequencer.
module tb_fetch_ctrl;

   localparam int BOOT  = 4;
   localparam int DRAIN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pc_src = 1'b0;
   logic       mem_read = 1'b0;
   logic [4:0] ex_rt = '0;
   logic [4:0] rs = '0;
   logic [4:0] rt = '0;
   logic       uses_rt = 1'b0;
   logic       halt_req = 1'b0;
   logic       resume = 1'b0;

   logic        pw, iw, ifl, idf, exf, hlt;
   logic [15:0] scnt, fcnt;
   logic        s_pw, s_iw, s_ifl, s_idf, s_exf, s_hlt;
   logic [1:0]  s_scnt, s_fcnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.BOOT_CYCLES(BOOT), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .ex_mem_pc_src(pc_src),
      .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt), .if_id_rs(rs),
      .if_id_rt(rt), .if_id_uses_rt(uses_rt), .halt_req(halt_req),
      .resume(resume), .pc_write(pw), .if_id_write(iw),
      .if_id_flush(ifl), .id_ex_flush(idf), .ex_mem_flush(exf),
      .halted(hlt), .stall_cnt(scnt), .flush_cnt(fcnt)
   );

   fetch_ctrl #(.BOOT_CYCLES(BOOT), .DRAIN_CYCLES(DRAIN), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .ex_mem_pc_src(pc_src),
      .id_ex_mem_read(mem_read), .id_ex_rt(ex_rt), .if_id_rs(rs),
      .if_id_rt(rt), .if_id_uses_rt(uses_rt), .halt_req(halt_req),
      .resume(resume), .pc_write(s_pw), .if_id_write(s_iw),
      .if_id_flush(s_ifl), .id_ex_flush(s_idf), .ex_mem_flush(s_exf),
      .halted(s_hlt), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
   );

   // Model: mode plus "cycles left in this mode" and unbounded event totals
   localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
   int m_mode = M_BOOT;
   int m_left = 0;
   int m_stalls = 0;
   int m_flushes = 0;
   bit m_valid = 1'b0;

   function automatic bit lu_hazard();
      return mem_read && ex_rt != 0 &&
             (ex_rt == rs || (uses_rt && ex_rt == rt));
   endfunction

   function automatic int sat(int v, int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid   = 1'b1;
         m_mode    = M_BOOT;
         m_left    = BOOT;
         m_stalls  = 0;
         m_flushes = 0;
      end else if (m_valid) begin
         case (m_mode)
            M_BOOT: begin
               m_left--;
               if (m_left == 0) m_mode = M_RUN;
            end
            M_RUN: begin
               if (pc_src) m_flushes++;
               else if (lu_hazard()) m_stalls++;
               if (halt_req) begin
                  m_mode = M_DRAIN;
                  m_left = DRAIN;
               end
            end
            M_DRAIN: begin
               if (pc_src) m_flushes++;
               m_left--;
               if (m_left == 0) m_mode = M_HALT;
            end
            default: if (resume) m_mode = M_RUN;
         endcase
      end
   end

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (m_valid) begin
         bit e_pw, e_iw, e_ifl, e_idf, e_exf, e_hlt;
         e_pw = 0; e_iw = 0; e_ifl = 0; e_idf = 0; e_exf = 0; e_hlt = 0;
         case (m_mode)
            M_BOOT: begin e_ifl = 1; e_idf = 1; e_exf = 1; end
            M_RUN:
               if (pc_src) begin
                  e_pw = 1; e_iw = 1; e_ifl = 1; e_idf = 1; e_exf = 1;
               end else if (lu_hazard()) e_idf = 1;
               else begin e_pw = 1; e_iw = 1; end
            M_DRAIN: begin
               e_ifl = 1;
               if (pc_src) begin e_pw = 1; e_idf = 1; e_exf = 1; end
            end
            default: begin e_hlt = 1; e_ifl = 1; end
         endcase
         chk("pc_write", int'(pw), int'(e_pw));
         if (m_mode == M_RUN) chk("if_id_write", int'(iw), int'(e_iw));
         chk("if_id_flush", int'(ifl), int'(e_ifl));
         chk("id_ex_flush", int'(idf), int'(e_idf));
         chk("ex_mem_flush", int'(exf), int'(e_exf));
         chk("halted", int'(hlt), int'(e_hlt));
         chk("stall_cnt", int'(scnt), sat(m_stalls, 16));
         chk("flush_cnt", int'(fcnt), sat(m_flushes, 16));
         chk("sat_pc_write", int'(s_pw), int'(e_pw));
         chk("sat_halted", int'(s_hlt), int'(e_hlt));
         chk("sat_stall_cnt", int'(s_scnt), sat(m_stalls, 2));
         chk("sat_flush_cnt", int'(s_fcnt), sat(m_flushes, 2));
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_src = 0; mem_read = 0; ex_rt = 0; rs = 0; rt = 0;
      uses_rt = 0; halt_req = 0; resume = 0;
   endtask

   initial begin
      cyc(2);
      rst = 0;
      for (int i = 0; i < BOOT; i++) begin
         #3;
         chk("boot_pw", int'(pw), 0);
         chk("boot_ifl", int'(ifl), 1);
         cyc();
      end
      #3;
      chk("run_pw", int'(pw), 1);
      chk("run_iw", int'(iw), 1);
      chk("run_flushes", int'({ifl, idf, exf}), 0);
      cyc();

      mem_read = 1; ex_rt = 5; rs = 5;
      #3;
      chk("lu_pw", int'(pw), 0);
      chk("lu_iw", int'(iw), 0);
      chk("lu_idf", int'(idf), 1);
      cyc();
      idle();
      #3;
      chk("lu_cnt", int'(scnt), 1);
      mem_read = 1; ex_rt = 0; rs = 0;
      #1;
      chk("lu_r0_pw", int'(pw), 1);
      cyc();

      mem_read = 1; ex_rt = 7; rs = 7; pc_src = 1;
      #3;
      chk("redir_pw", int'(pw), 1);
      chk("redir_flushes", int'({ifl, idf, exf}), 7);
      cyc();
      idle();
      #3;
      chk("redir_fcnt", int'(fcnt), 1);
      chk("redir_scnt", int'(scnt), 1);
      cyc();

      halt_req = 1;
      cyc();
      halt_req = 0;
      for (int k = 1; k <= DRAIN; k++) begin
         pc_src = (k == 2);
         #3;
         chk("drain_pw", int'(pw), (k == 2) ? 1 : 0);
         chk("drain_halted", int'(hlt), 0);
         cyc();
         pc_src = 0;
      end
      #3;
      chk("halted_t5", int'(hlt), 1);
      chk("drain_fcnt", int'(fcnt), 2);
      resume = 1;
      cyc();
      resume = 0;
      #3;
      chk("resume_halted", int'(hlt), 0);
      chk("resume_pw", int'(pw), 1);

      pc_src = 1;
      cyc(5);
      pc_src = 0;
      #3;
      chk("sat_fcnt_lit", int'(s_fcnt), 3);
      chk("wide_fcnt_lit", int'(fcnt), 7);

      halt_req = 1;
      cyc();
      halt_req = 0;
      cyc();
      rst = 1;
      cyc();
      rst = 0;
      #3;
      chk("rst_scnt", int'(scnt), 0);
      chk("rst_fcnt", int'(fcnt), 0);
      chk("rst_halted", int'(hlt), 0);
      chk("rst_pw", int'(pw), 0);
      cyc();

      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 249) == 0);
         pc_src   = ($urandom_range(0, 5) == 0);
         mem_read = $urandom_range(0, 1);
         ex_rt    = 5'($urandom_range(0, 5));
         rs       = 5'($urandom_range(0, 5));
         rt       = 5'($urandom_range(0, 5));
         uses_rt  = $urandom_range(0, 1);
         halt_req = ($urandom_range(0, 39) == 0);
         resume   = ($urandom_range(0, 3) == 0);
         cyc();
      end
      idle();
      rst = 0;
      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
